// File: rtl/spi_master_core.sv
// SPI master shift engine: pops bytes from a show-ahead TX FIFO, shifts them out MSB-first and
// pushes each received byte into the RX FIFO, holding cs_n low across back-to-back bytes.
module spi_master_core #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             tx_empty,
  input  logic [7:0]       tx_data,
  output logic             tx_rd,
  input  logic             rx_full,
  output logic [7:0]       rx_data,
  output logic             rx_wr,
  output logic             rx_overflow,
  input  logic             ovf_clr,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLast, StGap} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [7:0]       tx_sr_q;
  logic [7:0]       rx_sr_q;
  logic [4:0]       edge_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             cs_n_q;
  logic             tx_rd_q;
  logic             rx_wr_q;
  logic             rx_ovf_q;
  logic             busy_q;
  logic [7:0]       rx_data_q;

  logic       tick;
  logic [4:0] edge_nx;
  logic       sample;
  logic       drive;
  logic       start;
  logic [7:0] rx_byte;

  always_comb begin
    tick    = (cnt_q == div_q);
    edge_nx = edge_q + 5'd1;
    // cpha=0 samples on odd (leading) edges, cpha=1 on even (trailing) edges.
    sample  = edge_nx[0] ^ cpha_q;
    drive   = !sample && (cpha_q || (edge_nx != 5'd16));
    start   = en && !tx_empty;
    // With cpha=1 the last sample lands on edge 16 itself, so fold miso in directly.
    rx_byte = cpha_q ? {rx_sr_q[6:0], miso} : rx_sr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      edge_q    <= 5'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      tx_rd_q   <= 1'b0;
      rx_wr_q   <= 1'b0;
      rx_ovf_q  <= 1'b0;
      busy_q    <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      tx_rd_q <= 1'b0;
      rx_wr_q <= 1'b0;
      cnt_q   <= tick ? '0 : cnt_q + DIV_W'(1);
      // A same-cycle overflow below overrides this clear.
      if (ovf_clr) rx_ovf_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          cnt_q  <= '0;
          sclk_q <= cpol;
          cs_n_q <= 1'b1;
          mosi_q <= 1'b0;
          if (start) begin
            tx_rd_q <= 1'b1;
            tx_sr_q <= tx_data;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            div_q   <= clk_div;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            edge_q  <= 5'd0;
            state_q <= StLoad;
            if (!cpha) mosi_q <= tx_data[7];
          end
        end

        StLoad, StShift: begin
          if (tick) begin
            if (state_q == StLoad) state_q <= StShift;
            edge_q <= edge_nx;
            sclk_q <= ~sclk_q;
            if (sample) begin
              rx_sr_q <= {rx_sr_q[6:0], miso};
            end else if (drive) begin
              mosi_q  <= cpha_q ? tx_sr_q[7] : tx_sr_q[6];
              tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
            if (edge_nx == 5'd16) begin
              rx_data_q <= rx_byte;
              if (rx_full) rx_ovf_q <= 1'b1;
              else         rx_wr_q  <= 1'b1;
              if (start) begin
                tx_rd_q <= 1'b1;
                tx_sr_q <= tx_data;
                edge_q  <= 5'd0;
                state_q <= StLoad;
                if (!cpha_q) mosi_q <= tx_data[7];
              end else begin
                state_q <= StLast;
              end
            end
          end
        end

        StLast: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            state_q <= StGap;
          end
        end

        StGap: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_rd       = tx_rd_q;
  assign rx_data     = rx_data_q;
  assign rx_wr       = rx_wr_q;
  assign rx_overflow = rx_ovf_q;
  assign busy        = busy_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: a small show-ahead FIFO model on the TX side, an SPI
// activity monitor, and hand-computed expectations for each scenario.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst, en, cpol, cpha, rx_full, ovf_clr;
  logic [7:0] clk_div;
  logic       tx_empty, tx_rd, rx_wr, rx_overflow, busy, sclk, mosi, miso, cs_n;
  logic [7:0] tx_data, rx_data;
  logic       loop_en, miso_tie;

  int vectors     = 0;
  int miscompares = 0;

  // TX FIFO model: initial block pushes, monitor pops on tx_rd.
  logic [7:0] fifo [0:7];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign tx_empty = (rd_ptr == wr_ptr);
  assign tx_data  = fifo[rd_ptr[2:0]];
  assign miso     = loop_en ? mosi : miso_tie;

  always #5 clk = ~clk;

  spi_master_core #(.DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cpol       (cpol),
    .cpha       (cpha),
    .clk_div    (clk_div),
    .tx_empty   (tx_empty),
    .tx_data    (tx_data),
    .tx_rd      (tx_rd),
    .rx_full    (rx_full),
    .rx_data    (rx_data),
    .rx_wr      (rx_wr),
    .rx_overflow(rx_overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n)
  );

  // Monitor: samples on the falling clk edge, away from DUT updates.
  int         cyc = 0, n_rd = 0, n_wr = 0, n_tog = 0, n_cs_rise = 0, n_cs_fall = 0, bad_rd = 0;
  int         last_rise = 0, rise_period = 0, last_tog = 0, rxwr_lag = -1;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [7:0] mosi_log = 8'h00;
  logic [7:0] rx_log [0:15];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= sclk;
    prev_cs   <= cs_n;
    if (tx_rd) begin
      n_rd <= n_rd + 1;
      if (tx_empty) bad_rd <= bad_rd + 1;
      else          rd_ptr <= rd_ptr + 1;
    end
    if (sclk !== prev_sclk) begin
      n_tog    <= n_tog + 1;
      last_tog <= cyc;
    end
    if (sclk && !prev_sclk) begin
      mosi_log    <= {mosi_log[6:0], mosi};
      rise_period <= cyc - last_rise;
      last_rise   <= cyc;
    end
    if (cs_n && !prev_cs) n_cs_rise <= n_cs_rise + 1;
    if (!cs_n && prev_cs) n_cs_fall <= n_cs_fall + 1;
    if (rx_wr) begin
      n_wr            <= n_wr + 1;
      rx_log[n_wr[3:0]] <= rx_data;
      rxwr_lag        <= (sclk !== prev_sclk) ? 0 : cyc - last_tog;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo[wr_ptr[2:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  int b_rd, b_wr, b_tog, b_csr, b_csf;

  task automatic snap();
    @(posedge clk); #1;
    b_rd  = n_rd;
    b_wr  = n_wr;
    b_tog = n_tog;
    b_csr = n_cs_rise;
    b_csf = n_cs_fall;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    check({tag, "_done"}, {31'd0, seen && !busy}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_togs(input int n, input string tag);
    int   togs = 0;
    logic prev = sclk;
    for (int i = 0; i < 400 && togs < n; i++) begin
      @(negedge clk);
      if (sclk !== prev) togs++;
      prev = sclk;
    end
    check(tag, togs, n);
  endtask

  logic [3:0] idx;

  initial begin
    rst = 1'b1; en = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1;
    rx_full = 1'b0; ovf_clr = 1'b0; loop_en = 1'b1; miso_tie = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_tx_rd", tx_rd, 0);
    check("rst_rx_wr", rx_wr, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_ovf", rx_overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, clk_div=1, loopback 0xA5
    snap();
    push(8'hA5);
    en = 1'b1;
    wait_done("m0");
    en = 1'b0;
    check("m0_tx_rd", n_rd - b_rd, 1);
    check("m0_rises", (n_tog - b_tog) / 2, 8);
    check("m0_period", rise_period, 4);
    check("m0_mosi", mosi_log, 8'hA5);
    check("m0_rx_wr", n_wr - b_wr, 1);
    idx = b_wr[3:0];
    check("m0_rx_data", rx_log[idx], 8'hA5);
    check("m0_cs_fall", n_cs_fall - b_csf, 1);
    check("m0_cs_rise", n_cs_rise - b_csr, 1);
    check("m0_cs_n", cs_n, 1);
    check("m0_busy", busy, 0);

    // Mode 3, clk_div=0, miso tied high, tx 0x3C
    cpol = 1'b1; cpha = 1'b1; clk_div = 8'd0; loop_en = 1'b0; miso_tie = 1'b1;
    repeat (2) @(negedge clk);
    check("m3_idle_sclk", sclk, 1);
    snap();
    push(8'h3C);
    en = 1'b1;
    wait_done("m3");
    en = 1'b0;
    check("m3_toggles", n_tog - b_tog, 16);
    check("m3_mosi", mosi_log, 8'h3C);
    idx = b_wr[3:0];
    check("m3_rx_data", rx_log[idx], 8'hFF);
    check("m3_rx_wr", n_wr - b_wr, 1);
    check("m3_rxwr_lag", rxwr_lag, 0);
    check("m3_sclk_end", sclk, 1);

    // Back-to-back 0x12, 0x34 in mode 0
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; loop_en = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    push(8'h12);
    push(8'h34);
    en = 1'b1;
    wait_done("b2b");
    en = 1'b0;
    check("b2b_tx_rd", n_rd - b_rd, 2);
    check("b2b_rx_wr", n_wr - b_wr, 2);
    idx = b_wr[3:0];
    check("b2b_rx0", rx_log[idx], 8'h12);
    idx = idx + 4'd1;
    check("b2b_rx1", rx_log[idx], 8'h34);
    check("b2b_cs_fall", n_cs_fall - b_csf, 1);
    check("b2b_cs_rise", n_cs_rise - b_csr, 1);

    // RX overflow: sticky, set beats same-cycle clear, clear alone works
    clk_div = 8'd0;
    snap();
    rx_full = 1'b1;
    push(8'h55);
    en = 1'b1;
    wait_done("ovf1");
    en = 1'b0;
    check("ovf1_no_wr", n_wr - b_wr, 0);
    check("ovf1_flag", rx_overflow, 1);
    repeat (3) @(negedge clk);
    check("ovf1_sticky", rx_overflow, 1);
    push(8'hAA);
    en = 1'b1;
    wait_togs(15, "ovf2_togs");
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf2_set_wins", rx_overflow, 1);
    wait_done("ovf2");
    en = 1'b0;
    check("ovf2_no_wr", n_wr - b_wr, 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr_alone", rx_overflow, 0);
    rx_full = 1'b0;

    // Reset mid-byte, then a clean transfer
    clk_div = 8'd1;
    snap();
    push(8'h5A);
    en = 1'b1;
    wait_togs(7, "rst_togs");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_busy", busy, 0);
    repeat (6) @(negedge clk);
    snap();
    check("mid_rst_no_wr", n_wr - b_wr, 0);
    push(8'hC3);
    en = 1'b1;
    wait_done("post_rst");
    en = 1'b0;
    check("post_rst_wr", n_wr - b_wr, 1);
    idx = b_wr[3:0];
    check("post_rst_rx", rx_log[idx], 8'hC3);
    check("post_rst_mosi", mosi_log, 8'hC3);

    // en dropped at edge 5 of the first of two queued bytes
    snap();
    push(8'h81);
    push(8'h7E);
    en = 1'b1;
    wait_togs(5, "endrop_togs");
    en = 1'b0;
    wait_done("endrop");
    check("endrop_tx_rd", n_rd - b_rd, 1);
    check("endrop_rx_wr", n_wr - b_wr, 1);
    idx = b_wr[3:0];
    check("endrop_rx", rx_log[idx], 8'h81);
    check("endrop_left", wr_ptr - rd_ptr, 1);
    check("endrop_cs_n", cs_n, 1);
    check("endrop_cs_rise", n_cs_rise - b_csr, 1);

    check("tx_rd_when_empty", bad_rd, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- SPI master shift engine; the reader of the SPI TX byte FIFO and the writer of the SPI RX byte FIFO.
- Pops bytes from a show-ahead TX FIFO (data valid whenever not empty; a one-cycle read strobe pops) and serialises them MSB-first on MOSI.
- Samples MISO into a byte and pushes it into the RX FIFO.
- Holds chip select low across back-to-back bytes while the TX FIFO has data.

Parameters:
- DIV_W, 8, width of the clk_div input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  start and continue transfers; sampled at byte boundaries
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- clk_div  in  DIV_W  SCLK half-period is clk_div+1 clk cycles
- tx_empty  in  1  TX FIFO empty
- tx_data  in  8  TX FIFO head byte (show-ahead)
- tx_rd  out  1  one-cycle TX FIFO pop
- rx_full  in  1  RX FIFO full
- rx_data  out  8  received byte
- rx_wr  out  1  one-cycle RX FIFO push
- rx_overflow  out  1  sticky flag: a byte was dropped because rx_full was high
- ovf_clr  in  1  clears rx_overflow
- busy  out  1  high whenever state is not IDLE
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  1  active-low chip select

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, cs_n=1, sclk=0, mosi=0, tx_rd=0, rx_wr=0, rx_data=0x00, rx_overflow=0, busy=0. Applies immediately mid-frame; the partial byte is discarded.
- Half-period tick: counter cleared on entry to every state; tick when counter==clk_div_latched. One tick = clk_div+1 cycles.
- IDLE:
  - sclk follows cpol; cs_n=1.
  - If en && !tx_empty: assert tx_rd for that cycle, load the shift register from tx_data, latch cpol/cpha/clk_div, set cs_n=0, go to LOAD.
- LOAD:
  - Lasts one tick; provides CS setup time.
  - cpha=0: mosi=bit7 throughout LOAD.
  - At the tick go to SHIFT, edge count=1; that edge toggles sclk.
- SHIFT:
  - Each tick toggles sclk; edges are numbered 1..16. Odd edges are leading, even edges are trailing.
  - cpha=0: sample miso on odd edges; shift mosi to the next bit on even edges 2..14.
  - cpha=1: drive the next bit on odd edges (bit7 on edge 1); sample miso on even edges.
  - Sampled bits shift in MSB-first.
- On edge 16:
  - Next cycle: rx_data=assembled byte. rx_wr=1 for one cycle if rx_full=0; otherwise rx_wr stays 0, rx_overflow<=1, and the byte is dropped.
  - Same cycle as the rx push: if en && !tx_empty, pulse tx_rd, load the next byte, go to LOAD with cs_n held low. Otherwise go to LAST.
- LAST: cs_n=0 and sclk=cpol for one tick (CS hold), then GAP.
- GAP: cs_n=1 for one tick, then IDLE.
- rx_overflow: set has priority over ovf_clr when both occur in the same cycle.
- en deasserted mid-byte: the current byte completes normally, then LAST.
- clk_div/cpol/cpha changes while busy: ignored until the next IDLE exit.
- tx_rd is only ever asserted when tx_empty=0. There is no pop while full/empty gating is active.
- busy=1 from the cycle after leaving IDLE until re-entry to IDLE.

Test Plan:
- Mode 0, clk_div=1, TX FIFO holds 0xA5, miso looped to mosi -> one tx_rd pulse; cs_n low; 8 sclk pulses with a 4-cycle period; mosi bit sequence 1,0,1,0,0,1,0,1; rx_wr pulses once with rx_data=0xA5; cs_n returns high after LAST+GAP; busy falls.
- Mode 3 (cpol=1, cpha=1), clk_div=0, miso tied 1, tx 0x3C -> sclk idles high; bit7 driven on edge 1; rx_data=0xFF; rx_wr pulse one cycle after edge 16.
- Back-to-back: FIFO holds 0x12 and 0x34, en held high -> two tx_rd pulses; cs_n stays low across both bytes; rx_wr pushes 0x12 then 0x34; cs_n rises only after the second byte.
- rx_full=1 during completion of byte 0x55 -> no rx_wr; rx_overflow=1 and stays set; ovf_clr=1 in the same cycle as a second overflow -> rx_overflow stays 1; ovf_clr alone -> 0.
- Assert rst at edge 7 mid-byte -> next cycle cs_n=1, sclk=0, busy=0, no rx_wr; a new transfer then completes correctly.
- en dropped at edge 5 of the first of two queued bytes -> the byte finishes and rx_wr fires; the second byte is not popped (tx_rd stays 0); cs_n deasserts.
